// File: rtl/requant_pkg.sv
// requant_pkg: shared widths, FSM state type and the int8 saturation helper for int16_requant_rows.
package requant_pkg;
  localparam int LANES = 64;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int ACC_W = 32;
  localparam int ROWS  = 64;
  localparam int SUM_W = ACC_W + 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [OUT_W-1:0] sat8(input logic signed [SUM_W-1:0] s);
    return s > SUM_W'(127) ? 8'h7f : s < -SUM_W'(128) ? 8'h80 : s[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: one element, round-half-up arithmetic shift, zero-point offset and int8 clamp.
// Optional REQUANT_RELU_EN floors the result at zero_point without flagging saturation.
module requant_lane import requant_pkg::*; (
  input  logic signed [ACC_W-1:0] prod_i,
  input  logic [4:0]              shift_i,
  input  logic signed [OUT_W-1:0] zp_i,
  output logic [OUT_W-1:0]        y_o,
  output logic                    sat_o
);
  logic signed [ACC_W:0]   ext, bias, r;
  logic signed [SUM_W-1:0] s;
  logic [OUT_W-1:0]        c;
  logic                    clamp;
  always_comb begin
    ext   = (ACC_W+1)'(prod_i);
    bias  = shift_i == 5'd0 ? '0 : {{ACC_W{1'b0}}, 1'b1} << (shift_i - 5'd1);
    r     = (ext + bias) >>> shift_i;
    s     = SUM_W'(r) + SUM_W'(zp_i);
    c     = sat8(s);
    clamp = SUM_W'($signed(c)) != s;
`ifdef REQUANT_RELU_EN
    y_o   = $signed(c) < zp_i ? zp_i : c;
    sat_o = clamp && $signed(c) >= zp_i;
`else
    y_o   = c;
    sat_o = clamp;
`endif
  end
endmodule

// File: rtl/int16_requant_rows.sv
// int16_requant_rows: requantizes 64 rows of 64 x int16 to int8 through a two-stage elastic pipeline
// under ap_ctrl_chain control; REQUANT_RELU_EN selects the ReLU floor in requant_lane.
module int16_requant_rows import requant_pkg::*; (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_idle,
  output logic                     ap_ready,
  output logic                     ap_done,
  input  logic                     ap_continue,
  input  logic [15:0]              mult,
  input  logic [4:0]               shift,
  input  logic [7:0]               zero_point,
  input  logic [LANES*IN_W-1:0]    in_tdata,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output logic [LANES*OUT_W-1:0]   out_tdata,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     out_tlast,
  output logic                     sat_flag
);
  state_t                     state_q, state_d;
  logic signed [IN_W-1:0]     mult_q;
  logic [4:0]                 shift_q;
  logic signed [OUT_W-1:0]    zp_q;
  logic [6:0]                 in_cnt_q, out_cnt_q;
  logic                       s1_v_q, s1_last_q;
  logic [LANES*ACC_W-1:0]     s1_q, prod;
  logic [LANES*OUT_W-1:0]     y;
  logic [LANES-1:0]           sat;
  logic                       s1_load, s2_load, in_hs, out_hs, start;
  assign s2_load   = !out_tvalid || out_tready;
  assign s1_load   = !s1_v_q || s2_load;
  assign in_tready = state_q == RUN && in_cnt_q < 7'(ROWS) && s1_load;
  assign in_hs     = in_tvalid && in_tready;
  assign out_hs    = out_tvalid && out_tready;
  assign start     = state_q == IDLE && ap_start;
  assign ap_idle   = state_q == IDLE;
  assign ap_ready  = state_q == IDLE;
  assign ap_done   = state_q == DONE;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ap_start ? RUN : IDLE;
      RUN:     state_d = out_hs && out_cnt_q == 7'(ROWS-1) ? DONE : RUN;
      DONE:    state_d = ap_continue ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod[i*ACC_W +: ACC_W] = ACC_W'($signed(in_tdata[i*IN_W +: IN_W])) * ACC_W'(mult_q);
    requant_lane u_lane (
      .prod_i  (s1_q[i*ACC_W +: ACC_W]),
      .shift_i (shift_q),
      .zp_i    (zp_q),
      .y_o     (y[i*OUT_W +: OUT_W]),
      .sat_o   (sat[i])
    );
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      mult_q     <= '0;
      shift_q    <= '0;
      zp_q       <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      s1_v_q     <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_q       <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mult_q    <= mult;
        shift_q   <= shift;
        zp_q      <= zero_point;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        sat_flag  <= 1'b0;
      end
      if (in_hs) in_cnt_q <= in_cnt_q + 7'd1;
      if (out_hs) out_cnt_q <= out_cnt_q + 7'd1;
      if (s1_load) begin
        s1_v_q <= in_hs;
        if (in_hs) begin
          s1_q      <= prod;
          s1_last_q <= in_cnt_q == 7'(ROWS-1);
        end
      end
      // S1 advances into S2 in the same cycle S2 drains, so no bubble
      if (s2_load) begin
        out_tvalid <= s1_v_q;
        if (s1_v_q) begin
          out_tdata <= y;
          out_tlast <= s1_last_q;
          if (|sat) sat_flag <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_int16_requant_rows.sv
// tb_int16_requant_rows: directed and randomized transactions checked against an integer reference model.
module tb_int16_requant_rows;
  localparam int ROWS = 64, LANES = 64;
  logic ap_clk = 0, ap_rst_n = 0, ap_start = 0, ap_continue = 0;
  logic ap_idle, ap_ready, ap_done;
  logic [15:0] mult = 0;
  logic [4:0] shift = 0;
  logic [7:0] zero_point = 0;
  logic [1023:0] in_tdata = '0;
  logic in_tvalid = 0, in_tready;
  logic [511:0] out_tdata;
  logic out_tvalid, out_tready = 0, out_tlast, sat_flag;
  int n_cmp = 0, n_bad = 0;
  logic [1023:0] rows [ROWS];
  logic [511:0] exp_rows [ROWS];
  bit exp_sat;
  int cm, csh, czp;
  always #5 ap_clk = ~ap_clk;
  int16_requant_rows dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue), .mult(mult),
    .shift(shift), .zero_point(zero_point), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast), .sat_flag(sat_flag)
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] ref_row(input logic [1023:0] r, input int m, input int sh,
                                           input int zp, output bit sat);
    logic [511:0] o;
    sat = 0;
    for (int l = 0; l < LANES; l++) begin
      longint x, p, q, s;
      x = longint'($signed(r[l*16 +: 16]));
      p = x * longint'(m);
      q = sh == 0 ? p : (p + (longint'(1) << (sh - 1))) >>> sh;
      s = q + longint'(zp);
      if (s > 127) begin s = 127; sat = 1; end
      if (s < -128) begin s = -128; sat = 1; end
      o[l*8 +: 8] = 8'(s);
    end
    return o;
  endfunction
  task automatic prepare();
    bit s;
    exp_sat = 0;
    for (int r = 0; r < ROWS; r++) begin
      exp_rows[r] = ref_row(rows[r], cm, csh, czp, s);
      exp_sat |= s;
    end
  endtask
  task automatic rand_cfg();
    cm  = int'($signed(16'($urandom)));
    csh = int'($urandom_range(6, 24));
    czp = int'($signed(8'($urandom)));
  endtask
  task automatic rand_rows();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) rows[r][l*16 +: 16] = 16'($urandom);
  endtask
  task automatic start_txn();
    check("pre_idle", ap_idle, 1);
    ap_start = 1; mult = 16'(cm); shift = 5'(csh); zero_point = 8'(czp);
    @(posedge ap_clk); #1;
    ap_start = 0; mult = 16'($urandom); shift = 5'($urandom); zero_point = 8'($urandom);
    check("run_not_idle", ap_idle, 0);
    check("sat_cleared", sat_flag, 0);
  endtask
  task automatic run_rows(input int mode, input int abort_row, output int fi, output int fo,
                          output bit aborted);
    int ii = 0, oi = 0, it = 0;
    bit held_v = 0;
    logic [511:0] held = '0;
    fi = -1; fo = -1; aborted = 0;
    while (oi < ROWS && it < 2000) begin
      if (abort_row >= 0 && ii == abort_row) begin aborted = 1; break; end
      in_tvalid  = ii < ROWS ? (mode == 2 ? $urandom_range(0, 2) != 0 : 1'b1) : 1'b1;
      in_tdata   = ii < ROWS ? rows[ii] : {32{$urandom}};
      out_tready = mode == 1 ? (it % 4 == 0 || it % 4 == 3) :
                   mode == 2 ? $urandom_range(0, 3) != 0 : 1'b1;
      @(negedge ap_clk);
      if (held_v) check("stall_hold", out_tdata, held);
      if (ii >= ROWS) check("extra_refused", in_tready, 0);
      if (out_tvalid && fo < 0) fo = it;
      if (out_tvalid && out_tready) begin
        check("row_data", out_tdata, exp_rows[oi]);
        check("row_tlast", out_tlast, oi == ROWS - 1);
        oi++;
      end
      held_v = out_tvalid && !out_tready;
      held   = out_tdata;
      if (in_tvalid && in_tready) begin
        if (fi < 0) fi = it;
        ii++;
      end
      @(posedge ap_clk); #1;
      it++;
    end
    in_tvalid = 0;
    if (!aborted && oi < ROWS) check("timeout_rows", 512'(oi), 512'(ROWS));
  endtask
  task automatic finish_txn(input bit hold_start);
    check("done", ap_done, 1);
    check("done_sat", sat_flag, exp_sat);
    check("done_tvalid", out_tvalid, 0);
    if (hold_start) begin
      ap_start = 1;
      repeat (3) begin
        @(posedge ap_clk); #1;
        check("start_ignored_done", {ap_done, ap_idle}, 2'b10);
      end
      ap_start = 0;
    end
    ap_continue = 1;
    @(posedge ap_clk); #1;
    ap_continue = 0;
    check("back_idle", {ap_idle, ap_ready, ap_done}, 3'b110);
    check("sat_sticky", sat_flag, exp_sat);
  endtask
  initial begin
    int fi, fo;
    bit ab;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1;
    check("rst_ctrl", {ap_idle, ap_ready, ap_done}, 3'b110);
    check("rst_out", {out_tvalid, out_tlast, sat_flag, in_tready}, 4'b0);
    check("rst_data", out_tdata, '0);
    // basic pass-through
    cm = 1; csh = 0; czp = 0;
    for (int r = 0; r < ROWS; r++) begin rows[r] = {64{16'd5}}; exp_rows[r] = {64{8'h05}}; end
    exp_sat = 0;
    start_txn(); run_rows(0, -1, fi, fo, ab);
    check("latency", 512'(fo - fi), 512'd2);
    finish_txn(1);
    // rounding with negative zero point
    cm = 3; csh = 2; czp = -1;
    for (int r = 0; r < ROWS; r++) begin rows[r] = {32{16'hFFF9, 16'h0007}}; exp_rows[r] = {32{8'hFA, 8'h04}}; end
    exp_sat = 0;
    start_txn(); run_rows(2, -1, fi, fo, ab); finish_txn(0);
    // saturation both ways
    cm = 256; csh = 0; czp = 0;
    for (int r = 0; r < ROWS; r++) begin rows[r] = {32{16'hFC18, 16'h03E8}}; exp_rows[r] = {32{8'h80, 8'h7F}}; end
    exp_sat = 1;
    start_txn(); run_rows(0, -1, fi, fo, ab); finish_txn(0);
    // 1-0-0-1 backpressure with random data
    rand_cfg(); rand_rows(); prepare();
    start_txn(); run_rows(1, -1, fi, fo, ab); finish_txn(1);
    // reset mid-transaction then a full run
    rand_cfg(); rand_rows(); prepare();
    start_txn(); run_rows(0, 30, fi, fo, ab);
    check("aborted", ab, 1);
    ap_rst_n = 0; #1;
    check("abort_ctrl", {ap_idle, ap_done, out_tvalid, out_tlast, sat_flag, in_tready}, 6'b100000);
    check("abort_data", out_tdata, '0);
    @(posedge ap_clk); #1 ap_rst_n = 1;
    rand_cfg(); rand_rows(); prepare();
    start_txn(); run_rows(2, -1, fi, fo, ab); finish_txn(1);
    // negative result without ReLU
    cm = 1; csh = 0; czp = 10;
    for (int r = 0; r < ROWS; r++) begin rows[r] = {64{16'hFFCE}}; exp_rows[r] = {64{8'hD8}}; end
    exp_sat = 0;
    start_txn(); run_rows(0, -1, fi, fo, ab); finish_txn(0);
    // random soak
    for (int k = 0; k < 4; k++) begin
      rand_cfg(); rand_rows(); prepare();
      start_txn(); run_rows(2, -1, fi, fo, ab); finish_txn(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
